// File: rtl/icache_pkg.sv
// icache_pkg: shared types and default geometry for the instruction cache.
package icache_pkg;

    localparam int SETS_DEF        = 8;
    localparam int BLOCK_WORDS_DEF = 2;
    localparam int IB_DEF          = $clog2(SETS_DEF);
    localparam int WB_DEF          = $clog2(BLOCK_WORDS_DEF);
    localparam int TB_DEF          = 30 - IB_DEF - WB_DEF;

    typedef enum logic {IDLE, FILL} icache_state_t;

    typedef struct packed {
        logic [TB_DEF-1:0] tag;
        logic [IB_DEF-1:0] idx;
        logic [WB_DEF-1:0] woff;
        logic [1:0]        bytoff;
    } icachef_t;

endpackage

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: miss fill FSM; walks a line word by word and strobes writes.
module icache_fill_ctrl
    import icache_pkg::*;
#(
    parameter int SETS        = SETS_DEF,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    localparam int IB = $clog2(SETS),
    localparam int WB = $clog2(BLOCK_WORDS),
    localparam int WW = (WB > 0) ? WB : 1,
    localparam int TW = 30 - IB - WB
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          start,
    input  logic [TW-1:0] start_tag,
    input  logic [IB-1:0] start_idx,
    input  logic          iwait,
    output logic          busy,
    output logic          iREN,
    output logic [31:0]   iaddr,
    output logic          wr_en,
    output logic [IB-1:0] wr_idx,
    output logic [WW-1:0] wr_woff,
    output logic          line_done,
    output logic [TW-1:0] fill_tag
);

    icache_state_t state_q, state_d;
    logic [WW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tag_q, tag_d;
    logic [IB-1:0] idx_q, idx_d;
    logic          acc, last;

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        busy      = state_q == FILL;
        acc       = busy && !iwait;
        last      = cnt_q == WW'(BLOCK_WORDS - 1);
        state_d   = !busy ? (start ? FILL : IDLE) : ((acc && last) ? IDLE : FILL);
        cnt_d     = !busy ? '0 : (acc ? (last ? '0 : cnt_q + WW'(1)) : cnt_q);
        tag_d     = (!busy && start) ? start_tag : tag_q;
        idx_d     = (!busy && start) ? start_idx : idx_q;
        iREN      = busy;
        iaddr     = busy ? ((32'(tag_q) << (IB + WB + 2)) | (32'(idx_q) << (WB + 2)) | (32'(cnt_q) << 2)) : '0;
        wr_en     = acc;
        wr_idx    = idx_q;
        wr_woff   = cnt_q;
        line_done = acc && last;
        fill_tag  = tag_q;
    end

endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with combinational hit path.
module icache
    import icache_pkg::*;
#(
    parameter int SETS        = SETS_DEF,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IB = $clog2(SETS);
    localparam int WB = $clog2(BLOCK_WORDS);
    localparam int WW = (WB > 0) ? WB : 1;
    localparam int TW = 30 - IB - WB;

    logic [SETS-1:0] valid_q, valid_d;
    logic [TW-1:0]   tag_q  [SETS];
    logic [TW-1:0]   tag_d  [SETS];
    logic [31:0]     data_q [SETS][BLOCK_WORDS];
    logic [31:0]     data_d [SETS][BLOCK_WORDS];
    logic [31:0]     hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    logic [TW-1:0]   req_tag, fill_tag;
    logic [IB-1:0]   req_idx, wr_idx;
    logic [WW-1:0]   req_woff, wr_woff;
    logic            busy, miss, wr_en, line_done, unused_bytoff;

    icache_fill_ctrl #(.SETS(SETS), .BLOCK_WORDS(BLOCK_WORDS)) u_fill (
        .CLK       (CLK),
        .nRST      (nRST),
        .start     (miss),
        .start_tag (req_tag),
        .start_idx (req_idx),
        .iwait     (iwait),
        .busy      (busy),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_woff   (wr_woff),
        .line_done (line_done),
        .fill_tag  (fill_tag)
    );

    always_comb begin
        unused_bytoff = ^imemaddr[1:0];
        req_tag       = imemaddr[31 -: TW];
        req_idx       = imemaddr[WB + 2 +: IB];
        req_woff      = (WB == 0) ? '0 : imemaddr[2 +: WW];
        ihit          = imemREN && !busy && valid_q[req_idx] && tag_q[req_idx] == req_tag;
        imemload      = ihit ? data_q[req_idx][req_woff] : '0;
        miss          = imemREN && !busy && !ihit;
        hit_count_d   = (ihit && hit_count_q != '1) ? hit_count_q + 32'd1 : hit_count_q;
        miss_count_d  = (miss && miss_count_q != '1) ? miss_count_q + 32'd1 : miss_count_q;
    end

    // A line being refilled is invalidated at the miss so a partial line never hits.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (miss)
            valid_d[req_idx] = 1'b0;
        if (line_done) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = fill_tag;
        end
        if (wr_en)
            data_d[wr_idx][wr_woff] = iload;
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            valid_q      <= '0;
            tag_q        <= '{default: '0};
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_ff @(posedge CLK)
        data_q <= data_d;

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench; stimulus queues expected fetches, a monitor checks them.
module tb_icache;

    logic        CLK, nRST, imemREN, ihit, iREN, iwait;
    logic [31:0] imemaddr, imemload, iaddr, iload, hit_count, miss_count;

    logic [31:0] exp_mem[$];
    logic [31:0] exp_hit[$];
    int          n_chk = 0, n_fail = 0;
    int          exp_hits = 0, exp_misses = 0;
    int          wcnt = 0;
    logic        waiting_prev = 1'b0;

    localparam int K = 2;

    icache dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hAAAA0000 | {16'h0, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model: K wait cycles before each word is delivered.
    initial begin
        iwait = 1'b1;
        iload = '0;
        forever begin
            @(posedge CLK);
            #1;
            wcnt  = (waiting_prev && iREN) ? wcnt + 1 : 0;
            iwait = !(iREN && wcnt >= K);
            iload = iREN ? mem_word(iaddr) : '0;
        end
    end

    initial forever begin
        @(negedge CLK);
        waiting_prev = iREN && iwait;
        if (iREN && !iwait) begin
            if (exp_mem.size() == 0) chk("mem_req_unexpected", 32'(iREN), 32'd0);
            else chk("mem_iaddr", iaddr, exp_mem.pop_front());
        end
        if (ihit) begin
            if (exp_hit.size() == 0) chk("ihit_unexpected", 32'(ihit), 32'd0);
            else chk("imemload", imemload, exp_hit.pop_front());
        end else
            chk("imemload_nohit", imemload, 32'd0);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_line(input logic [31:0] a);
        exp_mem.push_back(a & ~32'h7);
        exp_mem.push_back((a & ~32'h7) | 32'h4);
    endtask

    task automatic wait_hit(input int lat, input string nm);
        int n = 0;
        while (n < 50) begin
            @(negedge CLK);
            if (ihit) break;
            n++;
        end
        chk({"latency_", nm}, 32'(n), 32'(lat));
        step();
    endtask

    task automatic fetch_miss(input logic [31:0] a, input string nm);
        imemREN  = 1'b1;
        imemaddr = a;
        push_line(a);
        exp_hit.push_back(mem_word(a));
        exp_misses++;
        exp_hits++;
        wait_hit(2 * (K + 1) + 1, nm);
    endtask

    task automatic fetch_hit(input logic [31:0] a, input string nm);
        imemREN  = 1'b1;
        imemaddr = a;
        exp_hit.push_back(mem_word(a));
        exp_hits++;
        @(negedge CLK);
        chk({"ihit_", nm}, 32'(ihit), 32'd1);
        chk({"iren_on_hit_", nm}, 32'(iREN), 32'd0);
        step();
    endtask

    task automatic chk_cnt(input string nm);
        chk({"hit_count_", nm}, hit_count, 32'(exp_hits));
        chk({"miss_count_", nm}, miss_count, 32'(exp_misses));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        repeat (3) @(negedge CLK);
        chk("rst_ihit", 32'(ihit), 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iren", 32'(iREN), 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk_cnt("rst");
        step();
        nRST = 1'b1;
        step();
        fetch_miss(32'h0, "t1");
        chk_cnt("t1");
        fetch_hit(32'h4, "t2");
        chk_cnt("t2");
        fetch_miss(32'h40, "t3a");
        fetch_miss(32'h0, "t3b");
        chk_cnt("t3");
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        @(negedge CLK);
        chk("t4_ihit", 32'(ihit), 32'd0);
        chk("t4_imemload", imemload, 32'd0);
        chk("t4_iren", 32'(iREN), 32'd0);
        repeat (2) step();
        chk_cnt("t4");
        imemREN  = 1'b1;
        imemaddr = 32'h80;
        exp_mem.push_back(32'h80);
        begin
            int n = 0;
            while (n < 20) begin
                @(negedge CLK);
                if (iREN && !iwait) break;
                n++;
            end
            chk("t5_first_word_wait", 32'(n < 20), 32'd1);
        end
        step();
        chk("t5_iren_before_rst", 32'(iREN), 32'd1);
        nRST    = 1'b0;
        imemREN = 1'b0;
        #1;
        exp_hits   = 0;
        exp_misses = 0;
        chk("t5_iren_async", 32'(iREN), 32'd0);
        chk("t5_iaddr_rst", iaddr, 32'd0);
        chk("t5_ihit_rst", 32'(ihit), 32'd0);
        chk_cnt("t5_rst");
        #1;
        nRST = 1'b1;
        step();
        fetch_miss(32'h80, "t5");
        chk_cnt("t5");
        imemREN  = 1'b1;
        imemaddr = 32'h0;
        push_line(32'h0);
        exp_misses++;
        repeat (2) step();
        imemaddr = 32'h10;
        push_line(32'h10);
        exp_hit.push_back(mem_word(32'h10));
        exp_misses++;
        exp_hits++;
        wait_hit(12, "t6");
        fetch_hit(32'h0, "t6_back");
        chk_cnt("t6");
        imemREN = 1'b0;
        repeat (2) step();
        chk("exp_mem_left", 32'(exp_mem.size()), 32'd0);
        chk("exp_hit_left", 32'(exp_hit.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
